// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and default widths for the pipeline hazard controller.
// Optional EX/WB forwarding is selected with the HAZ_FWD_EN macro.
package pipe_ctrl_pkg;

  localparam int REG_NUM_W_DEFAULT = 3;
  localparam int CNT_W_DEFAULT     = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle: register-file hazard fields in, stage enables out.
// The pipeline datapath is the master; the hazard controller is the slave.
interface pipe_hazard_ctrl_if #(
  parameter int REG_NUM_W = pipe_ctrl_pkg::REG_NUM_W_DEFAULT
);

  logic                 id_valid;
  logic [REG_NUM_W-1:0] id_rs;
  logic                 id_rs_used;
  logic [REG_NUM_W-1:0] ex_rd;
  logic                 ex_we;
  logic [REG_NUM_W-1:0] ex_rs;
  logic                 ex_rs_used;
  logic [REG_NUM_W-1:0] wb_rd;
  logic                 wb_we;
  logic                 branch_taken;

  logic                 pc_en;
  logic                 if_id_en;
  logic                 if_id_flush;
  logic                 id_ex_bubble;
  logic                 fwd_sel;

  modport master (
    output id_valid, id_rs, id_rs_used,
    output ex_rd, ex_we, ex_rs, ex_rs_used,
    output wb_rd, wb_we, branch_taken,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, fwd_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used,
    input  ex_rd, ex_we, ex_rs, ex_rs_used,
    input  wb_rd, wb_we, branch_taken,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, fwd_sel
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW detection against ID/EX and EX/WB destinations.
// HAZ_FWD_EN enables the EX/WB -> ALU forwarding select.
module hazard_detect #(
  parameter int REG_NUM_W = pipe_ctrl_pkg::REG_NUM_W_DEFAULT
) (
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_NUM_W-1:0] id_rs,
  input  logic                 id_rs_used,
  input  logic [REG_NUM_W-1:0] ex_rd,
  input  logic                 ex_we,
  input  logic [REG_NUM_W-1:0] ex_rs,
  input  logic                 ex_rs_used,
  input  logic [REG_NUM_W-1:0] wb_rd,
  input  logic                 wb_we,
  output logic                 raw_ex,
  output logic                 raw_wb,
  output logic                 fwd_sel
);

  assign raw_ex = id_valid & id_rs_used & ex_we & (ex_rd == id_rs);
  assign raw_wb = id_valid & id_rs_used & wb_we & (wb_rd == id_rs);

`ifdef HAZ_FWD_EN
  // Gated by reset so the ALU mux sits on the register-file path while held in reset.
  assign fwd_sel = ex_rs_used & wb_we & (wb_rd == ex_rs) & rst_n;
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs, ex_rs_used, rst_n};
  assign fwd_sel = 1'b0;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / flush / halt-step controller with saturating stall counter.
// Build option: HAZ_FWD_EN (forwarding replaces RAW stalls).
//
// state | meaning
// RUN   | normal issue; stalls on RAW, flushes on taken branch
// FLUSH | second squash cycle after a taken branch
// HALT  | pipeline frozen by debug halt
// STEP  | single RUN-like cycle issued from HALT
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_NUM_W = REG_NUM_W_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic                Clk,
  input  logic                Reset,
  pipe_hazard_ctrl_if.slave   pipe,
  input  logic                halt_req,
  input  logic                step_req,
  output logic                halted,
  output logic [CNT_W-1:0]    stall_count
);

  state_e           state_q;
  state_e           state_d;
  logic             raw_ex;
  logic             raw_wb;
  logic             haz_stall;
  logic             fwd_sel;
  logic             stall_act;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_cnt_q;

  hazard_detect #(
    .REG_NUM_W (REG_NUM_W)
  ) u_hazard_detect (
    .rst_n      (Reset),
    .id_valid   (pipe.id_valid),
    .id_rs      (pipe.id_rs),
    .id_rs_used (pipe.id_rs_used),
    .ex_rd      (pipe.ex_rd),
    .ex_we      (pipe.ex_we),
    .ex_rs      (pipe.ex_rs),
    .ex_rs_used (pipe.ex_rs_used),
    .wb_rd      (pipe.wb_rd),
    .wb_we      (pipe.wb_we),
    .raw_ex     (raw_ex),
    .raw_wb     (raw_wb),
    .fwd_sel    (fwd_sel)
  );

`ifdef HAZ_FWD_EN
  logic unused_raw;
  assign unused_raw = raw_ex | raw_wb;
  assign haz_stall  = 1'b0;
`else
  assign haz_stall  = raw_ex | raw_wb;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (pipe.branch_taken) begin
          state_d = ST_FLUSH;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end
      end
      ST_FLUSH: begin
        state_d = halt_req ? ST_HALT : ST_RUN;
      end
      ST_HALT: begin
        if (step_req) begin
          state_d = ST_STEP;
        end else if (!halt_req) begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        state_d = pipe.branch_taken ? ST_FLUSH : ST_HALT;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // A halt request in RUN freezes issue immediately but is not counted as a hazard stall.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;
    stall_act    = 1'b0;
    if (!Reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN, ST_STEP: begin
          if (pipe.branch_taken) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
          end else if ((state_q == ST_RUN) && halt_req) begin
            id_ex_bubble = 1'b1;
          end else if (haz_stall) begin
            id_ex_bubble = 1'b1;
            stall_act    = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end
        end
        ST_FLUSH: begin
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        ST_HALT: begin
          id_ex_bubble = 1'b1;
          halted       = 1'b1;
        end
        default: begin
          id_ex_bubble = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_cnt_q <= '0;
    end else if (stall_act && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count       = stall_cnt_q;
  assign pipe.pc_en        = pc_en;
  assign pipe.if_id_en     = if_id_en;
  assign pipe.if_id_flush  = if_id_flush;
  assign pipe.id_ex_bubble = id_ex_bubble;
  assign pipe.fwd_sel      = fwd_sel;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have one parameter per line (name, default, meaning):
- REG_NUM_W, 3, register-number width.
- CNT_W, 8, stall-counter width.

REQ-002 SHALL have the following ports (name, direction, width, meaning):
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_rs  in  REG_NUM_W  IF/ID source register.
- id_rs_used  in  1  IF/ID instruction reads id_rs.
- ex_rd  in  REG_NUM_W  ID/EX destination register.
- ex_we  in  1  ID/EX RegWrite.
- ex_rs  in  REG_NUM_W  ID/EX source register.
- ex_rs_used  in  1  ID/EX instruction reads ex_rs.
- wb_rd  in  REG_NUM_W  EX/WB destination register.
- wb_we  in  1  EX/WB RegWrite.
- branch_taken  in  1  PCSrc asserted this cycle.
- halt_req  in  1  level; freeze the pipeline.
- step_req  in  1  pulse; advance one cycle while halted.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_bubble  out  1  load NOP (RegWrite=0) into ID/EX.
- fwd_sel  out  1  ALU takes EX/WB data instead of ID/EX read data.
- halted  out  1  controller in HALT.
- stall_count  out  CNT_W  saturating hazard-stall counter.

Function
REQ-003 SHALL implement FSM states RUN, FLUSH, HALT, STEP, registered on Clk.
REQ-004 SHALL compute raw_ex = id_valid & id_rs_used & ex_we & (ex_rd==id_rs).
REQ-005 SHALL compute raw_wb = id_valid & id_rs_used & wb_we & (wb_rd==id_rs).
REQ-006 SHALL decode all control outputs combinationally from current state and inputs, with zero latency.
REQ-007 In RUN with no event: pc_en=1, if_id_en=1, if_id_flush=0, id_ex_bubble=0.
REQ-008 In RUN with hazard stall active: pc_en=0, if_id_en=0, id_ex_bubble=1, and stall_count increments at the next edge, saturating at 2^CNT_W-1.
REQ-009 branch_taken in RUN or STEP: if_id_flush=1 the same cycle; next state FLUSH.
REQ-010 FLUSH SHALL last exactly one cycle with if_id_flush=1, id_ex_bubble=1, pc_en=1, then return to RUN, or to HALT if halt_req=1.
REQ-011 Priority within RUN SHALL be branch_taken > halt_req > hazard stall.
REQ-012 A hazard coinciding with branch_taken SHALL NOT stall and SHALL NOT increment stall_count.
REQ-013 halt_req=1 in RUN: next state HALT.
REQ-014 In HALT: pc_en=0, if_id_en=0, id_ex_bubble=1, halted=1; branch_taken SHALL be ignored.
REQ-015 step_req=1 in HALT: next state STEP.
REQ-016 halt_req=0 in HALT: next state RUN; step_req SHALL take priority over halt_req=0.
REQ-017 STEP SHALL last exactly one cycle with RUN output behaviour, including hazard stall; it then returns to HALT, or to FLUSH if branch_taken.
REQ-018 halted SHALL equal 1 exactly in HALT.

Reset
REQ-019 While Reset=0 at a rising edge: state<=RUN, stall_count<=0.
REQ-020 While Reset=0: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, fwd_sel=0, halted=0.
REQ-021 Reset deasserting mid-FLUSH, HALT or STEP SHALL resume in RUN with no pending step.

Configuration
REQ-022 Macro HAZ_FWD_EN defined: fwd_sel = ex_rs_used & wb_we & (wb_rd==ex_rs) & Reset; hazard stall = 0, because EX/WB forwarding covers RAW.
REQ-023 Macro HAZ_FWD_EN undefined: fwd_sel tied 0; hazard stall = raw_ex | raw_wb.

Structure
REQ-024 Package pipe_ctrl_pkg SHALL hold the state enum, REG_NUM_W and CNT_W defaults.
REQ-025 Sub-module hazard_detect (combinational; raw_ex, raw_wb, fwd_sel) SHALL be instantiated once.

Verification
REQ-026 Bench SHALL cover the following directed scenarios:
- Macro off, id_rs=3/used, ex_rd=3/ex_we=1 for 1 cycle, then wb_rd=3/wb_we=1 for 1 cycle -> 2 stall cycles, stall_count=2.
- Macro on, same stimulus -> no stall; fwd_sel=1 when ex_rs=3, wb_rd=3, wb_we=1.
- branch_taken pulse in RUN -> if_id_flush=1 for 2 consecutive cycles; RUN after.
- halt_req=1, then step_req pulse -> HALT, one STEP cycle with pc_en=1, back to HALT; halt_req=0 -> RUN.
- 260 forced stall cycles (macro off) -> stall_count=255.
- Reset=0 during HALT -> next cycle halted=0, stall_count=0, outputs per REQ-020.
